// File: rtl/exe_muldiv_unit_pkg.sv
// exe_muldiv_unit_pkg: md op and state encodings shared by the multiply/divide unit
package exe_muldiv_unit_pkg;
  localparam int MD_OP_W = 3;
  typedef enum logic [MD_OP_W-1:0] {
    OP_NOP, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_RSV
  } md_op_e;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} md_state_e;
endpackage

// File: rtl/exe_muldiv_unit_if.sv
// exe_muldiv_unit_if: EX-stage request / stall / HI-LO bundle of the md unit
interface exe_muldiv_unit_if
  import exe_muldiv_unit_pkg::*;
#(parameter int WIDTH = 32);
  logic start, flush, busy, done;
  logic [MD_OP_W-1:0] op;
  logic [WIDTH-1:0] src_a, src_b, hi_out, lo_out;
  modport master (output start, op, src_a, src_b, flush, input busy, done, hi_out, lo_out);
  modport slave (input start, op, src_a, src_b, flush, output busy, done, hi_out, lo_out);
endinterface

// File: rtl/radix2_divider.sv
// radix2_divider: unsigned restoring divider, one quotient bit per step
// quotient/remainder show the result of the pending step, so the final step is usable before its edge
module radix2_divider #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic [WIDTH:0] trial;
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, div_q};
  assign quotient = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  assign remainder = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      div_q <= divisor;
    end else if (step) begin
      rem_q <= remainder;
      quo_q <= quotient;
    end
endmodule

// File: rtl/exe_muldiv_unit.sv
// exe_muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU with architectural HI/LO and EX stall
module exe_muldiv_unit
  import exe_muldiv_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 4
) (
  input logic clk,
  input logic rst,
  exe_muldiv_unit_if.slave md
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  md_state_e state, state_n;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q, quo, rem, q_fix, r_fix, dvd, dvs;
  logic [CNT_W-1:0] cnt;
  logic sgn_q, go, is_mul, is_div, is_signed, neg_a, neg_b;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  assign is_mul = md.op == OP_MULT || md.op == OP_MULTU;
  assign is_div = md.op == OP_DIV || md.op == OP_DIVU;
  assign is_signed = md.op == OP_MULT || md.op == OP_DIV;
  assign go = state == S_IDLE && md.start && !md.flush;
  assign md.busy = (go && (is_mul || is_div)) || state == S_MUL || state == S_DIV;
  assign md.done = state == S_DONE;
  assign md.hi_out = hi_q;
  assign md.lo_out = lo_q;
  assign dvd = is_signed && md.src_a[WIDTH-1] ? -md.src_a : md.src_a;
  assign dvs = is_signed && md.src_b[WIDTH-1] ? -md.src_b : md.src_b;
  radix2_divider #(.WIDTH(WIDTH)) u_div (
    .clk(clk), .rst(rst), .load(go && is_div), .step(state == S_DIV),
    .dividend(dvd), .divisor(dvs), .quotient(quo), .remainder(rem)
  );
  assign neg_a = sgn_q & a_q[WIDTH-1];
  assign neg_b = sgn_q & b_q[WIDTH-1];
  // divide by zero bypasses sign fix-up: all-ones quotient, raw dividend as remainder
  assign q_fix = b_q == '0 ? '1 : (neg_a ^ neg_b) ? -quo : quo;
  assign r_fix = b_q == '0 ? a_q : neg_a ? -rem : rem;
  // low 2*WIDTH bits of the extended product are correct for both signednesses
  assign ext_a = {{WIDTH{neg_a}}, a_q};
  assign ext_b = {{WIDTH{neg_b}}, b_q};
  assign prod = ext_a * ext_b;
  always_comb begin
    state_n = state;
    if (md.flush) state_n = S_IDLE;
    else if (go && is_mul) state_n = S_MUL;
    else if (go && is_div) state_n = S_DIV;
    else if ((state == S_MUL || state == S_DIV) && cnt == '0) state_n = S_DONE;
    else if (state == S_DONE) state_n = S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      sgn_q <= 1'b0;
      cnt <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else if (go) begin
      if (is_mul || is_div) begin
        a_q <= md.src_a;
        b_q <= md.src_b;
        sgn_q <= is_signed;
        cnt <= is_mul ? CNT_W'(MUL_LAT - 1) : CNT_W'(WIDTH - 1);
      end
      if (md.op == OP_MTHI) hi_q <= md.src_a;
      if (md.op == OP_MTLO) lo_q <= md.src_a;
    end else if (!md.flush && (state == S_MUL || state == S_DIV)) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == '0) {hi_q, lo_q} <= state == S_MUL ? prod : {r_fix, q_fix};
    end
endmodule

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, instantiated beside the ALU in the execute stage.
- Executes MULT/MULTU/DIV/DIVU and MTHI/MTLO.
- Drives the arithmetic stall that holds EX until a result is ready.
- Adds configurable width, configurable multiply latency, iterative division, and flush/abort, none of which the current execute stage provides.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- MUL_LAT, 4: cycles spent in the MUL state (must be >= 1).
- CNT_W, $clog2(WIDTH+1): localparam, iteration counter width (must also cover MUL_LAT).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  EX holds a valid md instruction; held high by EX until busy drops.
- op  in  3  operation code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 reserved, treated as NOP.
- src_a  in  WIDTH  rs operand, already forwarded.
- src_b  in  WIDTH  rt operand, already forwarded.
- flush  in  1  pipeline flush / exception; aborts any operation.
- busy  out  1  arith stall to the hazard unit.
- done  out  1  one-cycle pulse: HI/LO just updated by a mul/div.
- hi_out  out  WIDTH  current HI.
- lo_out  out  WIDTH  current LO.

Behaviour:
- Reset (async, rst=1): state=IDLE, HI=0, LO=0, counter=0, operand/partial regs=0, busy=0, done=0. Reset mid-operation discards the operation immediately.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start=1, op=MULT/MULTU, flush=0:
  - Latch operands; counter=MUL_LAT-1; next state MUL.
- IDLE, start=1, op=DIV/DIVU, flush=0:
  - Latch |a|, |b| (signed) or raw values (unsigned), plus sign bits; counter=WIDTH-1; next state DIV.
- IDLE, MTHI/MTLO (start=1, flush=0):
  - HI or LO <= src_a at the next edge; state stays IDLE; busy stays 0; done stays 0.
- busy (combinational) = (state==IDLE & start & ~flush & op in {1..4}) | state==MUL | state==DIV.
  - MUL: busy high MUL_LAT+1 consecutive cycles.
  - DIV: busy high WIDTH+1 consecutive cycles.
- MUL:
  - Product of latched operands, signed or unsigned, 2*WIDTH bits.
  - Counter decrements each cycle.
  - At counter==0: {HI,LO} <= product; next state DONE.
- DIV:
  - One restoring radix-2 step per cycle, WIDTH steps.
  - On the last step, apply sign fix-up: quotient negative iff signs differ; remainder takes the dividend's sign.
  - LO <= quotient, HI <= remainder; next state DONE.
- Divide by zero (signed or unsigned): LO <= all ones, HI <= src_a as latched; full latency is still taken.
- Signed overflow: DIV of most-negative by -1 gives LO=most-negative, HI=0.
- DONE: done=1, busy=0; start is ignored (EX advances this cycle); next state IDLE.
- flush=1 in any state:
  - Next state IDLE; HI/LO unchanged; done=0 next cycle; busy gated to 0 in the IDLE term.
  - flush and start in the same cycle: flush wins, nothing is accepted (MTHI/MTLO included).
  - flush in DONE: HI/LO keep the completed result.
- Operand changes on src_a/src_b after acceptance have no effect.
- hi_out/lo_out are registered: the new value is visible the cycle after the write edge.

Decomposition:
- Shared package (defines): md op encodings, state encodings, MD_OP_W=3.
- One sub-module: radix2_divider.
  - Parametrised WIDTH.
  - Inputs: load, dividend, divisor, step.
  - Outputs: quotient, remainder.
  - Unsigned only; sign handling stays in exe_muldiv_unit.
- Multiplier is inline.

Test Plan:
- MULT: a=0xFFFFFFFD (-3), b=5, MUL_LAT=4 -> busy high 5 cycles, done pulse; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU: a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; repeat with MUL_LAT=1 -> busy high exactly 2 cycles.
- DIV: a=0xFFFFFFF9 (-7), b=2 -> busy high 33 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU: 100/7 -> LO=14, HI=2.
- DIVU: 100/0 -> LO=0xFFFFFFFF, HI=100. DIV: 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x1234 then MTLO 0x5678, back to back -> busy never high; hi_out=0x1234, lo_out=0x5678.
- Start DIV, flush on 10th busy cycle -> busy 0 next cycle, HI/LO keep prior values, no done. Assert rst mid-MUL -> all outputs 0 immediately.
